sad_min_select: RTL

SAD_MIN_SELECT -- requirements
Module: sad_min_select

---
 rtl/sad_min_select.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sad_min_select.sv
// Minimum-SAD selector: scans a 2^RLOG2 x 2^RLOG2 search window, four candidates per beat,
// through a two-stage compare pipeline and reports the winning SAD, position and motion vector.
module sad_min_select #(
    parameter int SWIDTH = 16,
    parameter int RLOG2  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sad_valid,
    input  logic [4*SWIDTH-1:0]   sad_in,
    output logic                  busy,
    output logic                  done,
    output logic [SWIDTH-1:0]     min_sad,
    output logic [RLOG2-1:0]      pos_x,
    output logic [RLOG2-1:0]      pos_y,
    output logic [RLOG2-1:0]      mv_x,
    output logic [RLOG2-1:0]      mv_y
);

    localparam int IW = 2 * RLOG2;
    localparam int BW = IW - 2;
    localparam logic [RLOG2-1:0] HALF = {1'b1, {(RLOG2-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SEARCH, FLUSH} state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic              s1_valid;
    logic              s1_last;
    logic [SWIDTH-1:0] s1_val;
    logic [IW-1:0]     s1_idx;
    logic              s2_last;
    logic [SWIDTH-1:0] run_min;
    logic [IW-1:0]     run_idx;

    logic [SWIDTH-1:0] lane [4];
    logic [SWIDTH-1:0] a_val, b_val, m_val;
    logic [1:0]        a_lane, b_lane, m_lane;
    logic              accept;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            lane[k] = sad_in[k*SWIDTH +: SWIDTH];
        end
    end

    // Strict less-than at every level keeps the lower lane on ties.
    always_comb begin
        a_val  = lane[0];
        a_lane = 2'd0;
        if (lane[1] < lane[0]) begin
            a_val  = lane[1];
            a_lane = 2'd1;
        end
        b_val  = lane[2];
        b_lane = 2'd2;
        if (lane[3] < lane[2]) begin
            b_val  = lane[3];
            b_lane = 2'd3;
        end
        m_val  = a_val;
        m_lane = a_lane;
        if (b_val < a_val) begin
            m_val  = b_val;
            m_lane = b_lane;
        end
    end

    assign accept = (state == SEARCH) && sad_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_val   <= '0;
            s1_idx   <= '0;
            s2_last  <= 1'b0;
            run_min  <= '1;
            run_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            min_sad  <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            mv_x     <= '0;
            mv_y     <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept && (beat == '1);
            if (accept) begin
                s1_val <= m_val;
                s1_idx <= {beat, m_lane};
            end

            if (s1_valid && (s1_val < run_min)) begin
                run_min <= s1_val;
                run_idx <= s1_idx;
            end

            s2_last <= s1_valid && s1_last;
            done    <= s2_last;
            if (s2_last) begin
                min_sad <= run_min;
                pos_x   <= run_idx[RLOG2-1:0];
                pos_y   <= run_idx[IW-1:RLOG2];
                mv_x    <= run_idx[RLOG2-1:0] - HALF;
                mv_y    <= run_idx[IW-1:RLOG2] - HALF;
            end

            // busy spans the done cycle so a back-to-back start keeps it high.
            if ((state == IDLE) && start) begin
                busy <= 1'b1;
            end else if (done && (state == IDLE)) begin
                busy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SEARCH;
                        beat    <= '0;
                        run_min <= '1;
                        run_idx <= '0;
                    end
                end
                SEARCH: begin
                    if (sad_valid) begin
                        beat <= beat + BW'(1);
                        if (beat == '1) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
